// File: rtl/ir_move_controller.sv
// Queues IR direction commands and applies at most one cursor move per video frame,
// with saturating clamps to the visible area.
module ir_move_controller #(
  parameter int H_MAX  = 639,
  parameter int V_MAX  = 479,
  parameter int STEP   = 8,
  parameter int X_INIT = 320,
  parameter int Y_INIT = 240,
  parameter int DEPTH  = 4
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Up,
  input  logic                     Down,
  input  logic                     Left,
  input  logic                     Right,
  input  logic                     Readable,
  input  logic                     Frame_Start,
  output logic [9:0]               Pos_X,
  output logic [9:0]               Pos_Y,
  output logic                     Moved,
  output logic                     Invalid,
  output logic                     Overflow,
  output logic [$clog2(DEPTH):0]   Queue_Count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, ARMED, APPLY} state_t;

  state_t          state_q, state_d;
  logic            readable_q;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [1:0]      cmd_q, cmd_d;
  logic [9:0]      pos_x_q, pos_x_d;
  logic [9:0]      pos_y_q, pos_y_d;
  logic            moved_q, moved_d;
  logic            invalid_q, invalid_d;
  logic            overflow_q, overflow_d;
  logic [1:0]      mem_q [DEPTH];

  logic            capture;
  logic            dir_valid;
  logic [1:0]      dir_code;
  logic            pop;
  logic            full;
  logic            push_req;
  logic            push;
  logic [10:0]     x_wide, y_wide, x_new, y_new;

  assign capture  = Readable & ~readable_q;
  assign pop      = (state_q == ARMED) & Frame_Start;
  assign full     = (count_q == CW'(DEPTH));
  assign push_req = capture & dir_valid;
  // A full FIFO still accepts a push when the head is popped in the same cycle
  assign push     = push_req & (~full | pop);

  always_comb begin
    dir_valid = 1'b0;
    dir_code  = 2'd0;
    unique case ({Up, Down, Left, Right})
      4'b1000: begin dir_valid = 1'b1; dir_code = 2'd0; end
      4'b0100: begin dir_valid = 1'b1; dir_code = 2'd1; end
      4'b0010: begin dir_valid = 1'b1; dir_code = 2'd2; end
      4'b0001: begin dir_valid = 1'b1; dir_code = 2'd3; end
      default: begin dir_valid = 1'b0; dir_code = 2'd0; end
    endcase
  end

  always_comb begin
    x_wide = {1'b0, pos_x_q};
    y_wide = {1'b0, pos_y_q};
    x_new  = x_wide;
    y_new  = y_wide;
    unique case (cmd_q)
      2'd0: y_new = (y_wide < 11'(STEP)) ? 11'd0 : y_wide - 11'(STEP);
      2'd1: y_new = (y_wide + 11'(STEP) > 11'(V_MAX)) ? 11'(V_MAX) : y_wide + 11'(STEP);
      2'd2: x_new = (x_wide < 11'(STEP)) ? 11'd0 : x_wide - 11'(STEP);
      2'd3: x_new = (x_wide + 11'(STEP) > 11'(H_MAX)) ? 11'(H_MAX) : x_wide + 11'(STEP);
      default: begin x_new = x_wide; y_new = y_wide; end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    cmd_d      = pop ? mem_q[rd_ptr_q] : cmd_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    moved_d    = 1'b0;
    invalid_d  = capture & ~dir_valid;
    overflow_d = push_req & full & ~pop;
    unique case (state_q)
      IDLE:  if (count_d != '0) state_d = ARMED;
      ARMED: if (pop) state_d = APPLY;
      APPLY: begin
        pos_x_d = x_new[9:0];
        pos_y_d = y_new[9:0];
        moved_d = (x_new != x_wide) | (y_new != y_wide);
        state_d = (count_d != '0) ? ARMED : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= IDLE;
      readable_q <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cmd_q      <= 2'd0;
      pos_x_q    <= 10'(X_INIT);
      pos_y_q    <= 10'(Y_INIT);
      moved_q    <= 1'b0;
      invalid_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      readable_q <= Readable;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cmd_q      <= cmd_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      moved_q    <= moved_d;
      invalid_q  <= invalid_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count
  always_ff @(posedge Clock) begin
    if (!Reset && push) mem_q[wr_ptr_q] <= dir_code;
  end

  assign Pos_X       = pos_x_q;
  assign Pos_Y       = pos_y_q;
  assign Moved       = moved_q;
  assign Invalid     = invalid_q;
  assign Overflow    = overflow_q;
  assign Queue_Count = count_q;

endmodule

// File: tb/tb_ir_move_controller.sv
// Self-checking bench for ir_move_controller: a queue-based behavioural model checked
// every cycle, plus literal expectations from hand-worked scenarios.
`timescale 1ns/1ps
module tb_ir_move_controller;

  localparam int H_MAX  = 639;
  localparam int V_MAX  = 479;
  localparam int STEP   = 8;
  localparam int X_INIT = 320;
  localparam int Y_INIT = 240;
  localparam int DEPTH  = 4;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Up = 1'b0, Down = 1'b0, Left = 1'b0, Right = 1'b0;
  logic       Readable = 1'b0;
  logic       Frame_Start = 1'b0;
  logic [9:0] Pos_X, Pos_Y;
  logic       Moved, Invalid, Overflow;
  logic [$clog2(DEPTH):0] Queue_Count;

  int passCount  = 0;
  int checkCount = 0;
  bit checkEn    = 1'b0;

  ir_move_controller #(
    .H_MAX(H_MAX), .V_MAX(V_MAX), .STEP(STEP),
    .X_INIT(X_INIT), .Y_INIT(Y_INIT), .DEPTH(DEPTH)
  ) dut (
    .Clock(Clock), .Reset(Reset),
    .Up(Up), .Down(Down), .Left(Left), .Right(Right),
    .Readable(Readable), .Frame_Start(Frame_Start),
    .Pos_X(Pos_X), .Pos_Y(Pos_Y), .Moved(Moved),
    .Invalid(Invalid), .Overflow(Overflow), .Queue_Count(Queue_Count)
  );

  always #5 Clock = ~Clock;

  // Behavioural model: a command queue, one pending move, and expected outputs
  int mq[$];
  bit mPending, mRdPrev, wasPending, doPop;
  int mDir, nx, ny, ones;
  int eX, eY, eCount;
  bit eMoved, eInv, eOvf;

  always @(posedge Clock) begin
    if (Reset) begin
      mq.delete();
      mPending = 1'b0;
      mRdPrev  = 1'b0;
      eX = X_INIT; eY = Y_INIT;
      eMoved = 1'b0; eInv = 1'b0; eOvf = 1'b0;
    end else begin
      eMoved = 1'b0; eInv = 1'b0; eOvf = 1'b0;
      wasPending = mPending;
      if (mPending) begin
        nx = eX; ny = eY;
        case (mDir)
          0: ny = (eY - STEP < 0) ? 0 : eY - STEP;
          1: ny = (eY + STEP > V_MAX) ? V_MAX : eY + STEP;
          2: nx = (eX - STEP < 0) ? 0 : eX - STEP;
          default: nx = (eX + STEP > H_MAX) ? H_MAX : eX + STEP;
        endcase
        eMoved = (nx != eX) || (ny != eY);
        eX = nx; eY = ny;
        mPending = 1'b0;
      end
      doPop = Frame_Start && (mq.size() > 0) && !wasPending;
      if (doPop) begin
        mDir = mq.pop_front();
        mPending = 1'b1;
      end
      if (Readable && !mRdPrev) begin
        ones = int'(Up) + int'(Down) + int'(Left) + int'(Right);
        if (ones != 1) eInv = 1'b1;
        else if (mq.size() == DEPTH) eOvf = 1'b1;
        else mq.push_back(Up ? 0 : Down ? 1 : Left ? 2 : 3);
      end
      mRdPrev = Readable;
    end
    eCount = mq.size();
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
  endtask

  // Every-cycle comparison against the model
  always @(negedge Clock) begin
    if (checkEn) begin
      checkOutput("Pos_X", int'(Pos_X), eX);
      checkOutput("Pos_Y", int'(Pos_Y), eY);
      checkOutput("Moved", int'(Moved), int'(eMoved));
      checkOutput("Invalid", int'(Invalid), int'(eInv));
      checkOutput("Overflow", int'(Overflow), int'(eOvf));
      checkOutput("Queue_Count", int'(Queue_Count), eCount);
    end
  end

  task automatic applyStimulus(input logic rst, input logic rd, input logic u, input logic d,
                               input logic l, input logic r, input logic fs);
    @(negedge Clock);
    Reset = rst; Readable = rd; Up = u; Down = d; Left = l; Right = r; Frame_Start = fs;
  endtask

  task automatic capture(input logic u, input logic d, input logic l, input logic r);
    applyStimulus(1'b0, 1'b1, u, d, l, r, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic frame();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkEn = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset Pos_X", int'(Pos_X), 320);
    checkOutput("reset Pos_Y", int'(Pos_Y), 240);
    checkOutput("reset Queue_Count", int'(Queue_Count), 0);

    $display("[TB] single Right move");
    capture(1'b0, 1'b0, 1'b0, 1'b1);
    frame();
    idle(3);
    checkOutput("right Pos_X", int'(Pos_X), 328);
    checkOutput("right Pos_Y", int'(Pos_Y), 240);

    $display("[TB] overflow and four Left moves");
    doReset();
    for (int i = 0; i < 5; i++) capture(1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("full Queue_Count", int'(Queue_Count), 4);
    for (int i = 0; i < 4; i++) frame();
    idle(3);
    checkOutput("left4 Pos_X", int'(Pos_X), 288);
    checkOutput("left4 Queue_Count", int'(Queue_Count), 0);

    $display("[TB] invalid encodings");
    capture(1'b1, 1'b0, 1'b1, 1'b0);
    capture(1'b0, 1'b0, 1'b0, 1'b0);
    idle(2);
    checkOutput("invalid Queue_Count", int'(Queue_Count), 0);
    checkOutput("invalid Pos_X", int'(Pos_X), 288);

    $display("[TB] clamp at top and right edges");
    doReset();
    for (int i = 0; i < 31; i++) begin
      capture(1'b1, 1'b0, 1'b0, 1'b0);
      frame();
      idle(2);
    end
    checkOutput("up clamp Pos_Y", int'(Pos_Y), 0);
    for (int i = 0; i < 41; i++) begin
      capture(1'b0, 1'b0, 1'b0, 1'b1);
      frame();
      idle(2);
    end
    checkOutput("right clamp Pos_X", int'(Pos_X), 639);

    $display("[TB] push into full FIFO during pop");
    doReset();
    for (int i = 0; i < 4; i++) capture(1'b0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("push+pop Queue_Count", int'(Queue_Count), 4);
    checkOutput("push+pop Overflow", int'(Overflow), 0);
    idle(2);

    $display("[TB] reset during APPLY");
    doReset();
    for (int i = 0; i < 3; i++) capture(1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    doReset();
    checkOutput("apply-reset Pos_X", int'(Pos_X), 320);
    checkOutput("apply-reset Pos_Y", int'(Pos_Y), 240);
    checkOutput("apply-reset Queue_Count", int'(Queue_Count), 0);
    checkOutput("apply-reset Moved", int'(Moved), 0);
    frame();
    idle(3);
    checkOutput("post-reset Pos_X", int'(Pos_X), 320);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #500000;
    checkCount++;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
